ir_frame_tx: RTL and testbench

//  Transmit side of the IR link. Serialises a parallel data word into a

---
 rtl/ir_frame_tx_pkg.sv | 36 +++
 rtl/ir_carrier_gen.sv | 55 +++++
 rtl/ir_frame_tx.sv | 122 ++++++++++++
 tb/tb_ir_frame_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ir_frame_tx_pkg.sv
// Shared IR link definitions: frame FSM state encodings, default timing
// constants and small sizing helpers used by transmit and receive sides.
package ir_frame_tx_pkg;

  typedef logic [2:0] ir_state_t;

  localparam ir_state_t ST_IDLE      = 3'd0;
  localparam ir_state_t ST_HDR_MARK  = 3'd1;
  localparam ir_state_t ST_HDR_SPACE = 3'd2;
  localparam ir_state_t ST_BIT_MARK  = 3'd3;
  localparam ir_state_t ST_BIT_SPACE = 3'd4;
  localparam ir_state_t ST_STOP_MARK = 3'd5;
  localparam ir_state_t ST_GAP       = 3'd6;

  localparam int DEF_CARRIER_HALF  = 6;
  localparam int DEF_UNIT_CARRIERS = 21;
  localparam int DEF_HDR_MARK_U    = 16;
  localparam int DEF_HDR_SPACE_U   = 8;
  localparam int DEF_ONE_SPACE_U   = 3;
  localparam int DEF_ZERO_SPACE_U  = 1;
  localparam int DEF_GAP_U         = 4;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_mark(input ir_state_t s);
    return (s == ST_HDR_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase generator. phase is the value for the upcoming cycle so the
// caller can register it; unit_tick flags the last cycle of each timing unit.
module ir_carrier_gen
  import ir_frame_tx_pkg::*;
#(
  parameter int CARRIER_HALF  = DEF_CARRIER_HALF,
  parameter int UNIT_CARRIERS = DEF_UNIT_CARRIERS
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase,
  output logic unit_tick
);
  localparam int CW = cw(CARRIER_HALF);
  localparam int HW = cw(2 * UNIT_CARRIERS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic          half_end, unit_end;

  assign half_end = (cnt_q == CW'(CARRIER_HALF - 1));
  assign unit_end = half_end && (half_q == HW'(2 * UNIT_CARRIERS - 1));

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    half_d  = half_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      half_d  = '0;
      phase_d = 1'b1;
    end else if (half_end) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
      half_d  = unit_end ? '0 : half_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end

  assign phase     = phase_d;
  assign unit_tick = unit_end;
endmodule

// File: rtl/ir_frame_tx.sv
// IR pulse-distance frame transmitter: header, DATA_W bits LSB first,
// stop mark, trailing gap. Marks are carrier-modulated, spaces are low.
module ir_frame_tx
  import ir_frame_tx_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CARRIER_HALF  = DEF_CARRIER_HALF,
  parameter int UNIT_CARRIERS = DEF_UNIT_CARRIERS,
  parameter int HDR_MARK_U    = DEF_HDR_MARK_U,
  parameter int HDR_SPACE_U   = DEF_HDR_SPACE_U,
  parameter int ONE_SPACE_U   = DEF_ONE_SPACE_U,
  parameter int ZERO_SPACE_U  = DEF_ZERO_SPACE_U,
  parameter int GAP_U         = DEF_GAP_U,
  parameter int CARRIER_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ir_out,
  output logic              busy
);
  localparam int SEG_MAX = imax(imax(imax(HDR_MARK_U, HDR_SPACE_U), imax(ONE_SPACE_U, ZERO_SPACE_U)),
                                imax(GAP_U, 1));
  localparam int SW = cw(SEG_MAX);
  localparam int BW = cw(DATA_W);

  ir_state_t         state_q, state_d;
  logic [SW-1:0]     seg_q, seg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              in_ready_q, in_ready_d;
  logic              ir_out_q, ir_out_d;
  logic              restart, phase, unit_tick, seg_last;
  int                seg_len;

  ir_carrier_gen #(
    .CARRIER_HALF  (CARRIER_HALF),
    .UNIT_CARRIERS (UNIT_CARRIERS)
  ) u_carrier (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .phase     (phase),
    .unit_tick (unit_tick)
  );

  always_comb begin
    case (state_q)
      ST_HDR_MARK:  seg_len = HDR_MARK_U;
      ST_HDR_SPACE: seg_len = HDR_SPACE_U;
      ST_BIT_SPACE: seg_len = shreg_q[0] ? ONE_SPACE_U : ZERO_SPACE_U;
      ST_GAP:       seg_len = GAP_U;
      default:      seg_len = 1;
    endcase
    seg_last = (seg_q == SW'(seg_len - 1));
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q == ST_IDLE) begin
      if (in_valid && in_ready_q) begin
        state_d = ST_HDR_MARK;
        shreg_d = in_data;
        seg_d   = '0;
        bit_d   = '0;
      end
    end else if (unit_tick) begin
      seg_d = seg_q + SW'(1);
      if (seg_last) begin
        seg_d = '0;
        case (state_q)
          ST_HDR_MARK:  state_d = ST_HDR_SPACE;
          ST_HDR_SPACE: state_d = ST_BIT_MARK;
          ST_BIT_MARK:  state_d = ST_BIT_SPACE;
          ST_BIT_SPACE: begin
            shreg_d = shreg_q >> 1;
            if (bit_q == BW'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = ST_STOP_MARK;
            end else begin
              bit_d   = bit_q + BW'(1);
              state_d = ST_BIT_MARK;
            end
          end
          ST_STOP_MARK: state_d = ST_GAP;
          default:      state_d = ST_IDLE;
        endcase
      end
    end
    // Realign the carrier whenever a mark begins so every mark starts high.
    restart    = is_mark(state_d) && (state_d != state_q);
    in_ready_d = (state_d == ST_IDLE);
    ir_out_d   = is_mark(state_d) && ((CARRIER_EN != 0) ? phase : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seg_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      in_ready_q <= 1'b0;
      ir_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      in_ready_q <= in_ready_d;
      ir_out_q   <= ir_out_d;
    end
  end

  assign in_ready = in_ready_q;
  assign ir_out   = ir_out_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ir_frame_tx.sv
// Directed bench for ir_frame_tx: expected ir_out waveforms are queued per
// accepted word and compared cycle by cycle as the frame is emitted.
module tb_ir_frame_tx;
  localparam int DW = 4;
  localparam int CH = 2;
  localparam int UC = 2;
  localparam int U  = 2 * CH * UC;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data, b_data;
  logic          in_valid, b_valid;
  logic          in_ready, ir_out, busy;
  logic          b_ready, b_ir_out, b_busy;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  ir_frame_tx #(.DATA_W(DW), .CARRIER_HALF(CH), .UNIT_CARRIERS(UC), .GAP_U(4), .CARRIER_EN(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ir_out(ir_out), .busy(busy));

  ir_frame_tx #(.DATA_W(DW), .CARRIER_HALF(CH), .UNIT_CARRIERS(UC), .GAP_U(4), .CARRIER_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .ir_out(b_ir_out), .busy(b_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seg(input bit mark, input int units, input bit car_en);
    for (int i = 0; i < units * U; i++)
      exp_q.push_back(mark ? (car_en ? ((i % (2 * CH)) < CH) : 1'b1) : 1'b0);
  endtask

  task automatic push_frame(input logic [DW-1:0] w, input bit car_en);
    push_seg(1, 16, car_en);
    push_seg(0, 8, car_en);
    for (int b = 0; b < DW; b++) begin
      push_seg(1, 1, car_en);
      push_seg(0, w[b] ? 3 : 1, car_en);
    end
    push_seg(1, 1, car_en);
    push_seg(0, 4, car_en);
  endtask

  // Called in cycle 1 of a frame; returns in cycle F+1.
  task automatic drain(input bit sel_b, input bit noise);
    int n;
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      check(sel_b ? "b_ir_out" : "ir_out", sel_b ? b_ir_out : ir_out, exp_q.pop_front());
      if (i == 1) check("busy_first", sel_b ? b_busy : busy, 1);
      if (i == n) check("ready_last", sel_b ? b_ready : in_ready, 0);
      if (noise) begin
        in_valid = ((i % 37) == 5);
        in_data  = DW'($urandom);
      end
      step();
    end
    if (noise) in_valid = 1'b0;
    check("ready_after", sel_b ? b_ready : in_ready, 1);
    check("busy_after", sel_b ? b_busy : busy, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; b_valid = 1'b0; b_data = '0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ir_out", ir_out, 0);
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
    end
    reset = 1'b0;
    step();
    check("ready_post_rst", in_ready, 1);
    check("b_ready_post_rst", b_ready, 1);

    // single word 0101
    in_data = 4'b0101; in_valid = 1'b1;
    step();
    push_frame(4'b0101, 1);
    in_valid = 1'b0;
    check("ready_fall", in_ready, 0);
    drain(0, 0);

    // in_valid held: F then 0 back-to-back
    in_data = 4'hF; in_valid = 1'b1;
    step();
    push_frame(4'hF, 1);
    in_data = 4'h0;
    drain(0, 0);
    step();
    push_frame(4'h0, 1);
    in_valid = 1'b0;
    drain(0, 0);

    // noise on in_valid/in_data while busy must not disturb the frame
    in_data = 4'b0101; in_valid = 1'b1;
    step();
    push_frame(4'b0101, 1);
    in_valid = 1'b0;
    drain(0, 1);

    // reset in the middle of the first bit space
    in_data = 4'b0101; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 205; i++) step();
    check("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    check("midrst_ir_out", ir_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_midrst", in_ready, 1);
    in_data = 4'h3; in_valid = 1'b1;
    step();
    push_frame(4'h3, 1);
    in_valid = 1'b0;
    drain(0, 0);

    // steady marks, 296-cycle frame on the unmodulated instance
    b_data = 4'h0; b_valid = 1'b1;
    step();
    push_frame(4'h0, 0);
    b_valid = 1'b0;
    check("b_frame_len", exp_q.size(), 296);
    drain(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
